ppu_xin_sequencer: RTL
======================

# ppu_xin_sequencer

Command-driven sequencer that generates the single-cycle control pulses (xin high/low, PPU reset set/clear) for the PPU clock/reset control register. It turns host commands into timed XIN waveforms, counted step bursts, free-running clocking and a full PPU reset sequence. It sits between the host command decoder and the PPU control block, which consumes its pulse outputs one-for-one.

## Interface
Parameters:
- HALF_PERIOD, 4: system clocks per XIN half-period; legal range 1..255.
- RESET_HOLD, 8: full XIN cycles clocked while PPU reset is held asserted; legal range 1..255.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0=STEP, 1=RESET_SEQ, 2=RUN, 3=reserved (accepted, no effect, done pulse).
- cmd_count  in  16  STEP only: number of full XIN cycles.
- stop_i  in  1  level or pulse; ends RUN, or aborts STEP/RESET_SEQ at next cycle boundary.
- xin_hi_o  out  1  one-cycle pulse: drive XIN high.
- xin_lo_o  out  1  one-cycle pulse: drive XIN low.
- set_ppu_reset_o  out  1  one-cycle pulse: assert PPU reset.
- clr_ppu_reset_o  out  1  one-cycle pulse: release PPU reset.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at command completion.
- xin_cycles  out  32  count of xin_lo_o pulses since reset; wraps 0xFFFFFFFF→0.

## Operation
- States: IDLE, HI (XIN high half), LO (XIN low half), RST_SET, RST_CLR, FINISH.
- cmd_ready = 1 only in IDLE and not in reset; accept on cmd_valid & cmd_ready.
- STEP, count N>0: loop N times {xin_hi_o; HI for HALF_PERIOD clocks; xin_lo_o; LO for HALF_PERIOD clocks}; then FINISH. N=0: straight to FINISH, no XIN pulses.
- RUN: as STEP with unbounded count; ends only via stop_i.
- RESET_SEQ: RST_SET emits set_ppu_reset_o; RESET_HOLD XIN cycles as above; RST_CLR emits clr_ppu_reset_o; FINISH.
- stop_i sampled every clock while busy; latched into a sticky flag, cleared on entering IDLE. Flag checked only at end of a LO half (cycle boundary): go to FINISH instead of next HI. XIN is therefore always left low. Stop during RESET_SEQ skips remaining hold cycles but still emits clr_ppu_reset_o.
- stop_i in IDLE: ignored, not latched.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Never more than one of the four pulse outputs high in a cycle; xin_hi_o/xin_lo_o strictly alternate, starting with hi.
- Internal counters: half-period counter 8 bits, cycle counter 16 bits; no arithmetic overflow for legal parameters.

## Timing
- Reset (reset=0 at a posedge): next cycle state IDLE, all pulse outputs 0, busy=0, done=0, cmd_ready=0 while reset low, 1 in first cycle after reset high, xin_cycles=0, stop flag clear. Reset mid-command aborts with no further pulses and no done.
- Accept in cycle T (STEP/RUN): xin_hi_o at T+1; xin_lo_o at T+1+HALF_PERIOD; next xin_hi_o at T+1+2·HALF_PERIOD.
- STEP N: last xin_lo_o at T+1+(2N−1)·HALF_PERIOD; done at T+1+2N·HALF_PERIOD; cmd_ready high the following cycle. N=0: done at T+1.
- RESET_SEQ: set_ppu_reset_o at T+1; first xin_hi_o at T+2; clr_ppu_reset_o at T+2+2·RESET_HOLD·HALF_PERIOD; done one cycle later.
- busy high T+1 through done cycle inclusive.
- xin_cycles updates the cycle after each xin_lo_o.
- Back-to-back: earliest next accept is cycle after done.

## Test plan
- Reset then STEP N=3, HALF_PERIOD=2: hi pulses at T+1,5,9; lo at T+3,7,11; done T+13; xin_cycles=3.
- STEP N=0: no XIN pulses, done at T+1, busy high exactly one cycle.
- RESET_SEQ, RESET_HOLD=2, HALF_PERIOD=2: set at T+1, hi at T+2,6, lo at T+4,8, clr at T+10, done T+11.
- RUN, stop_i pulsed one cycle mid-HI of 5th cycle: 5th lo pulse still emitted, no 6th hi, done next boundary, XIN left low.
- Reset asserted during STEP N=100 HI half: no lo pulse, no done, busy=0 and xin_cycles=0 after reset; new STEP accepted normally.
- cmd_valid held during busy and stop_i in IDLE: no second accept until after done; idle stop has no effect on next RUN.

Source files
------------

// File: rtl/ppu_xin_sequencer.sv
// Command-driven sequencer producing single-cycle XIN and PPU-reset control pulses.
// Handles counted STEP bursts, free-running RUN, and a full PPU reset sequence.
module ppu_xin_sequencer #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned RESET_HOLD  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic        stop_i,
    output logic        xin_hi_o,
    output logic        xin_lo_o,
    output logic        set_ppu_reset_o,
    output logic        clr_ppu_reset_o,
    output logic        busy,
    output logic        done,
    output logic [31:0] xin_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_RST_SET,
        S_RST_CLR,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        M_STEP,
        M_RUN,
        M_RSEQ
    } mode_t;

    typedef enum logic [1:0] {
        OP_STEP      = 2'd0,
        OP_RESET_SEQ = 2'd1,
        OP_RUN       = 2'd2,
        OP_RESERVED  = 2'd3
    } op_t;

    localparam logic [7:0]  HALF_LAST   = 8'(HALF_PERIOD - 1);
    localparam logic [15:0] HOLD_CYCLES = 16'(RESET_HOLD);

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [7:0]  half_q, half_d;
    logic [15:0] cyc_q, cyc_d;
    logic        stop_q, stop_d;
    logic [31:0] xin_cycles_q;

    logic accept;
    logic half_end;
    logic stop_seen;
    logic last_cycle;
    logic hi_pulse, lo_pulse, set_pulse, clr_pulse, done_pulse;

    assign accept     = cmd_valid && cmd_ready;
    assign half_end   = (half_q == HALF_LAST);
    assign stop_seen  = stop_q || stop_i;
    assign last_cycle = (mode_q != M_RUN) && (cyc_q == 16'd1);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        half_d     = half_q;
        cyc_d      = cyc_q;
        stop_d     = stop_q;
        hi_pulse   = 1'b0;
        lo_pulse   = 1'b0;
        set_pulse  = 1'b0;
        clr_pulse  = 1'b0;
        done_pulse = 1'b0;

        // Stop requests are only remembered while a command is in flight.
        if (state_q != S_IDLE && stop_i) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                half_d = 8'd0;
                if (accept) begin
                    unique case (op_t'(cmd_op))
                        OP_STEP: begin
                            mode_d  = M_STEP;
                            cyc_d   = cmd_count;
                            state_d = (cmd_count == 16'd0) ? S_FINISH : S_HI;
                        end
                        OP_RUN: begin
                            mode_d  = M_RUN;
                            state_d = S_HI;
                        end
                        OP_RESET_SEQ: begin
                            mode_d  = M_RSEQ;
                            cyc_d   = HOLD_CYCLES;
                            state_d = S_RST_SET;
                        end
                        default: state_d = S_FINISH;
                    endcase
                end
            end
            S_HI: begin
                hi_pulse = (half_q == 8'd0);
                if (half_end) begin
                    half_d  = 8'd0;
                    state_d = S_LO;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            S_LO: begin
                lo_pulse = (half_q == 8'd0);
                if (half_end) begin
                    half_d = 8'd0;
                    // Cycle boundary: the only point where a stop takes effect, so XIN ends low.
                    if (stop_seen || last_cycle) begin
                        state_d = (mode_q == M_RSEQ) ? S_RST_CLR : S_FINISH;
                    end else begin
                        state_d = S_HI;
                        if (mode_q != M_RUN) begin
                            cyc_d = cyc_q - 16'd1;
                        end
                    end
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            S_RST_SET: begin
                set_pulse = 1'b1;
                half_d    = 8'd0;
                state_d   = S_HI;
            end
            S_RST_CLR: begin
                clr_pulse = 1'b1;
                state_d   = S_FINISH;
            end
            S_FINISH: begin
                done_pulse = 1'b1;
                stop_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mode_q       <= M_STEP;
            half_q       <= 8'd0;
            cyc_q        <= 16'd0;
            stop_q       <= 1'b0;
            xin_cycles_q <= 32'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            half_q  <= half_d;
            cyc_q   <= cyc_d;
            stop_q  <= stop_d;
            if (lo_pulse) begin
                xin_cycles_q <= xin_cycles_q + 32'd1;
            end
        end
    end

    // Outputs are masked while reset is low so an aborted command emits nothing further.
    assign cmd_ready       = reset && (state_q == S_IDLE);
    assign busy            = reset && (state_q != S_IDLE);
    assign done            = reset && done_pulse;
    assign xin_hi_o        = reset && hi_pulse;
    assign xin_lo_o        = reset && lo_pulse;
    assign set_ppu_reset_o = reset && set_pulse;
    assign clr_ppu_reset_o = reset && clr_pulse;
    assign xin_cycles      = xin_cycles_q;

endmodule
